// File: rtl/audio_pkg.sv
// Shared audio constants: default clocking, widths, divider FSM states and
// the note frequency table consumed by the music sequencer.
package audio_pkg;

    localparam int CLK_HZ_DEFAULT = 100_000_000;
    localparam int HZ_W           = 12;
    localparam int CNT_W          = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Equal-tempered notes rounded to the nearest Hz; octave 4 through 5.
    localparam logic [HZ_W-1:0] NO_VOICE = 12'd0;
    localparam logic [HZ_W-1:0] NOTE_C4  = 12'd262;
    localparam logic [HZ_W-1:0] NOTE_CS4 = 12'd277;
    localparam logic [HZ_W-1:0] NOTE_D4  = 12'd294;
    localparam logic [HZ_W-1:0] NOTE_DS4 = 12'd311;
    localparam logic [HZ_W-1:0] NOTE_E4  = 12'd330;
    localparam logic [HZ_W-1:0] NOTE_F4  = 12'd349;
    localparam logic [HZ_W-1:0] NOTE_FS4 = 12'd370;
    localparam logic [HZ_W-1:0] NOTE_G4  = 12'd392;
    localparam logic [HZ_W-1:0] NOTE_GS4 = 12'd415;
    localparam logic [HZ_W-1:0] NOTE_A4  = 12'd440;
    localparam logic [HZ_W-1:0] NOTE_AS4 = 12'd466;
    localparam logic [HZ_W-1:0] NOTE_B4  = 12'd494;
    localparam logic [HZ_W-1:0] NOTE_C5  = 12'd523;
    localparam logic [HZ_W-1:0] NOTE_CS5 = 12'd554;
    localparam logic [HZ_W-1:0] NOTE_D5  = 12'd587;
    localparam logic [HZ_W-1:0] NOTE_DS5 = 12'd622;
    localparam logic [HZ_W-1:0] NOTE_E5  = 12'd659;
    localparam logic [HZ_W-1:0] NOTE_F5  = 12'd698;
    localparam logic [HZ_W-1:0] NOTE_FS5 = 12'd740;
    localparam logic [HZ_W-1:0] NOTE_G5  = 12'd784;
    localparam logic [HZ_W-1:0] NOTE_GS5 = 12'd831;
    localparam logic [HZ_W-1:0] NOTE_A5  = 12'd880;
    localparam logic [HZ_W-1:0] NOTE_AS5 = 12'd932;
    localparam logic [HZ_W-1:0] NOTE_B5  = 12'd988;

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// done is high during the final iteration; quotient is valid the next cycle.
module seq_divider #(
    parameter int N_W = 26,
    parameter int D_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [N_W-1:0] quotient
);

    localparam int C_W = $clog2(N_W + 1);

    logic [N_W-1:0] rem_reg;
    logic [N_W-1:0] quo_reg;
    logic [N_W-1:0] div_reg;
    logic [C_W-1:0] cnt_reg;
    logic           run_reg;

    logic [N_W-1:0] rem_shift;
    logic [N_W-1:0] rem_sub;
    logic           sub_ok;

    // The remainder stays below the divisor (D_W < N_W), so the shifted-out
    // MSB is always zero and N_W bits are enough for the trial subtraction.
    always_comb begin
        rem_shift = {rem_reg[N_W-2:0], quo_reg[N_W-1]};
        sub_ok    = (rem_shift >= div_reg);
        rem_sub   = rem_shift - div_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg <= '0;
            quo_reg <= '0;
            div_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (start) begin
            rem_reg <= '0;
            quo_reg <= dividend;
            div_reg <= N_W'(divisor);
            cnt_reg <= C_W'(N_W);
            run_reg <= 1'b1;
        end else if (run_reg) begin
            rem_reg <= sub_ok ? rem_sub : rem_shift;
            quo_reg <= {quo_reg[N_W-2:0], sub_ok};
            cnt_reg <= cnt_reg - C_W'(1);
            if (cnt_reg == C_W'(1)) begin
                run_reg <= 1'b0;
            end
        end
    end

    assign done     = run_reg && (cnt_reg == C_W'(1));
    assign quotient = quo_reg;

endmodule

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: divides CLK_HZ/2 by the requested tone at run time
// and swaps the half-period only on a toggle boundary so the output never glitches.
module buzzer_tone_gen
    import audio_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int HZ_W   = audio_pkg::HZ_W,
    parameter int CNT_W  = audio_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [HZ_W-1:0] hz,
    output logic            buzzer,
    output logic            busy,
    output logic            tone_active
);

    localparam logic [CNT_W-1:0] HALF_CLK = CNT_W'(CLK_HZ / 2);
    localparam logic [CNT_W-1:0] MIN_HALF = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    div_state_t      state_reg;
    div_state_t      state_next;
    logic [HZ_W-1:0] hz_latched_reg;
    logic [CNT_W-1:0] pending_reg;
    logic            pending_valid_reg;
    logic [CNT_W-1:0] half_cur_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic            buzzer_reg;

    logic            hz_change;
    logic            div_start;
    logic            div_done;
    logic [CNT_W-1:0] div_quotient;
    logic [CNT_W-1:0] quo_floor;
    logic            done_commit;
    logic            silence_req;
    logic            new_valid;
    logic [CNT_W-1:0] new_val;
    logic            eff_valid;
    logic [CNT_W-1:0] eff_val;
    logic            terminal;

    assign hz_change = (hz != hz_latched_reg);

    seq_divider #(
        .N_W(CNT_W),
        .D_W(HZ_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (HALF_CLK),
        .divisor  (hz),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (hz_change && (hz != '0)) state_next = DIV;
            DIV:  if (div_done) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        div_start = (state_reg == IDLE) && hz_change && (hz != '0);
        busy      = (state_reg == DIV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hz_latched_reg <= '0;
        end else if ((state_reg == IDLE) && hz_change) begin
            hz_latched_reg <= hz;
        end
    end

    // A result computed for an hz that has since moved is dropped here;
    // IDLE will see the difference on the next cycle and start over.
    always_comb begin
        quo_floor   = (div_quotient < MIN_HALF) ? MIN_HALF : div_quotient;
        done_commit = (state_reg == DONE) && !hz_change;
        silence_req = (state_reg == IDLE) && hz_change && (hz == '0);
        new_valid   = done_commit || silence_req;
        new_val     = done_commit ? quo_floor : '0;
        eff_valid   = new_valid || pending_valid_reg;
        eff_val     = new_valid ? new_val : pending_reg;
        terminal    = (half_cur_reg != '0) && (cnt_reg == half_cur_reg - ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            half_cur_reg      <= '0;
            cnt_reg           <= '0;
            buzzer_reg        <= 1'b0;
        end else if (half_cur_reg != '0) begin
            if (terminal) begin
                cnt_reg <= '0;
                if (eff_valid) begin
                    half_cur_reg      <= eff_val;
                    pending_valid_reg <= 1'b0;
                    buzzer_reg        <= (eff_val == '0) ? 1'b0 : ~buzzer_reg;
                end else begin
                    buzzer_reg <= ~buzzer_reg;
                end
            end else begin
                cnt_reg           <= cnt_reg + ONE;
                pending_reg       <= eff_val;
                pending_valid_reg <= eff_valid;
            end
        end else begin
            // Silent: a waiting period is consumed straight away, while a
            // value arriving this same cycle is kept for the next boundary.
            cnt_reg    <= '0;
            buzzer_reg <= 1'b0;
            if (pending_valid_reg) begin
                half_cur_reg <= pending_reg;
            end
            pending_valid_reg <= new_valid;
            if (new_valid) begin
                pending_reg <= new_val;
            end
        end
    end

    assign buzzer      = buzzer_reg;
    assign tone_active = (half_cur_reg != '0);

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at CLK_HZ=1 MHz, CNT_W=20; expected
// half-periods are floor(500000/hz): 440->1136, 880->568, 523->956.
module tb_buzzer_tone_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] hz;
    logic        buzzer;
    logic        busy;
    logic        tone_active;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    buzzer_tone_gen #(
        .CLK_HZ(1_000_000),
        .HZ_W  (12),
        .CNT_W (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hz         (hz),
        .buzzer     (buzzer),
        .busy       (busy),
        .tone_active(tone_active)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sample(input int sel);
        case (sel)
            0:       return buzzer;
            1:       return busy;
            default: return tone_active;
        endcase
    endfunction

    // Ticks until the selected output reaches level; n = ticks taken, -1 on timeout.
    task automatic wait_sig(input int sel, input logic level, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (sample(sel) == level) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        int n;
        int busy_seen;
        int buzz_seen;

        rst = 1'b1;
        hz  = 12'd440;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", {29'd0, buzzer, busy, tone_active}, 0);
        end

        rst = 1'b0;
        tick();
        check("busy_after_release", busy, 1);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy) break;
            n++;
        end
        check("busy_cycles_440", n, 20);
        tick();
        check("tone_active_before_commit", tone_active, 0);
        tick();
        check("tone_active_at_commit", tone_active, 1);
        check("buzzer_low_at_commit", buzzer, 0);

        wait_sig(0, 1'b1, 3000, n); check("first_rise_440", n, 1136);
        wait_sig(0, 1'b0, 3000, n); check("high_440", n, 1136);
        wait_sig(0, 1'b1, 3000, n); check("low_440", n, 1136);

        // Mid-tone change: the current high half finishes at the old length.
        hz = 12'd880;
        wait_sig(0, 1'b0, 3000, n); check("high_before_880", n, 1136);
        wait_sig(0, 1'b1, 3000, n); check("low_880", n, 568);
        wait_sig(0, 1'b0, 3000, n); check("high_880", n, 568);

        // Change while dividing: the 440 result must never be used.
        hz = 12'd440;
        for (int i = 0; i < 5; i++) tick();
        check("busy_during_div", busy, 1);
        hz = 12'd523;
        wait_sig(0, 1'b1, 3000, n); check("low_880_tail", n, 563);
        wait_sig(0, 1'b0, 3000, n); check("high_523", n, 956);
        wait_sig(0, 1'b1, 3000, n); check("low_523", n, 956);
        wait_sig(0, 1'b0, 3000, n); check("high_523_b", n, 956);

        // Silence requested during a low half: next boundary holds buzzer low.
        hz = 12'd0;
        busy_seen = 0;
        buzz_seen = 0;
        n = -1;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (busy) busy_seen++;
            if (buzzer) buzz_seen++;
            if (!tone_active) begin
                n = i;
                break;
            end
        end
        check("silence_boundary", n, 956);
        for (int i = 0; i < 500; i++) begin
            tick();
            if (busy) busy_seen++;
            if (buzzer) buzz_seen++;
        end
        check("silence_busy_cycles", busy_seen, 0);
        check("silence_buzzer_high_cycles", buzz_seen, 0);
        check("silence_tone_active", tone_active, 0);

        // Reset in the middle of a division.
        hz = 12'd440;
        for (int i = 0; i < 5; i++) tick();
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_div_outputs", {29'd0, buzzer, busy, tone_active}, 0);
        rst = 1'b0;
        tick();
        check("busy_after_rst_div", busy, 1);
        wait_sig(2, 1'b1, 100, n);  check("commit_after_rst_div", n, 22);
        wait_sig(0, 1'b1, 3000, n); check("rise_after_rst_div", n, 1136);

        // Reset in the middle of a high half-period.
        for (int i = 0; i < 300; i++) tick();
        check("buzzer_high_before_rst", buzzer, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_tone_outputs", {29'd0, buzzer, busy, tone_active}, 0);
        rst = 1'b0;
        wait_sig(2, 1'b1, 100, n);  check("commit_after_rst_tone", n, 23);
        wait_sig(0, 1'b1, 3000, n); check("rise_after_rst_tone", n, 1136);
        wait_sig(0, 1'b0, 3000, n); check("high_after_rst_tone", n, 1136);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
